// File: rtl/mem_access_queue.sv
// Data-side memory access queue: issues load/store requests on an SRAM-like bus and returns aligned responses in order.
// Optional misaligned-access detection is compiled in with `define MEMQ_ALE_CHECK_EN.
module mem_access_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_wr,
    input  logic [1:0]              in_size,
    input  logic                    in_signed,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_wdata,
    input  logic                    flush,
    output logic                    data_sram_req,
    output logic                    data_sram_wr,
    output logic [1:0]              data_sram_size,
    output logic [DATA_WIDTH/8-1:0] data_sram_wstrb,
    output logic [ADDR_WIDTH-1:0]   data_sram_addr,
    output logic [DATA_WIDTH-1:0]   data_sram_wdata,
    input  logic                    data_sram_addr_ok,
    input  logic                    data_sram_data_ok,
    input  logic [DATA_WIDTH-1:0]   data_sram_rdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_is_load,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_ale,
    output logic                    busy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LW    = $clog2(BYTES);
    localparam int PW    = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic                  sgn;
        logic [LW-1:0]         lo;
        logic                  filled;
        logic                  cancel;
        logic [DATA_WIDTH-1:0] rdata;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic [PW-1:0]   alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
    logic [PW:0]     count_q, count_d;

    logic            ale_req, ale_accept, ale_pend, ale_wr;
    logic            accept, pop;
    entry_t          head;
    logic [7:0]      smask;
    logic [DATA_WIDTH-1:0] shifted, load_data;
    logic            sext;

`ifdef MEMQ_ALE_CHECK_EN
    logic       ale_pend_q, ale_pend_d, ale_wr_q, ale_wr_d;
    logic [2:0] amask;

    always_comb begin
        case (in_size)
            2'd0:    amask = 3'b000;
            2'd1:    amask = 3'b001;
            2'd2:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
    end

    assign ale_req    = |(in_addr[2:0] & amask);
    assign ale_accept = in_valid && ale_req && (count_q == '0) && !ale_pend_q && !flush && !reset;

    always_comb begin
        ale_pend_d = ale_pend_q;
        ale_wr_d   = ale_wr_q;
        if (flush) begin
            ale_pend_d = 1'b0;
        end else if (ale_accept) begin
            ale_pend_d = 1'b1;
            ale_wr_d   = in_wr;
        end else if (ale_pend_q && resp_ready) begin
            ale_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ale_pend_q <= 1'b0;
            ale_wr_q   <= 1'b0;
        end else begin
            ale_pend_q <= ale_pend_d;
            ale_wr_q   <= ale_wr_d;
        end
    end

    assign ale_pend = ale_pend_q;
    assign ale_wr   = ale_wr_q;
`else
    assign ale_req    = 1'b0;
    assign ale_accept = 1'b0;
    assign ale_pend   = 1'b0;
    assign ale_wr     = 1'b0;
`endif

    // Issue path is a pure pass-through of the MEM-stage request.
    assign data_sram_req  = in_valid && (count_q < FULL) && !flush && !ale_req && !reset;
    assign accept         = data_sram_req && data_sram_addr_ok;
    assign in_ready       = accept || ale_accept;
    assign data_sram_wr   = in_wr;
    assign data_sram_size = in_size;
    assign data_sram_addr = in_addr;

    always_comb begin
        case (in_size)
            2'd0:    smask = 8'h01;
            2'd1:    smask = 8'h03;
            2'd2:    smask = 8'h0F;
            default: smask = 8'hFF;
        endcase
    end

    assign data_sram_wstrb = BYTES'(smask) << in_addr[LW-1:0];

    assign head = ent_q[head_q];
    // A cancelled beat leaves the queue on its own; live ones wait behind a pending ALE response.
    assign pop  = head.filled && (head.cancel || (resp_ready && !flush && !ale_pend));

    always_comb begin
        ent_d   = ent_q;
        alloc_d = alloc_q;
        fill_d  = fill_q;
        head_d  = head_q;
        if (accept) begin
            ent_d[alloc_q].wr     = in_wr;
            ent_d[alloc_q].size   = in_size;
            ent_d[alloc_q].sgn    = in_signed;
            ent_d[alloc_q].lo     = in_addr[LW-1:0];
            ent_d[alloc_q].filled = 1'b0;
            ent_d[alloc_q].cancel = 1'b0;
            alloc_d = alloc_q + PW'(1);
        end
        if (data_sram_data_ok) begin
            ent_d[fill_q].rdata  = data_sram_rdata;
            ent_d[fill_q].filled = 1'b1;
            fill_d = fill_q + PW'(1);
        end
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i].cancel = 1'b1;
            end
        end
        if (pop) begin
            ent_d[head_q].filled = 1'b0;
            ent_d[head_q].cancel = 1'b0;
            head_d = head_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(accept) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_q <= '0;
            fill_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            head_q  <= head_d;
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end

    assign shifted = head.rdata >> {head.lo, 3'b000};

    always_comb begin
        case (head.size)
            2'd0:    sext = head.sgn && shifted[7];
            2'd1:    sext = head.sgn && shifted[15];
            2'd2:    sext = head.sgn && shifted[31];
            default: sext = head.sgn && shifted[DATA_WIDTH-1];
        endcase
    end

    for (genvar b = 0; b < BYTES; b++) begin : g_lane
        localparam int LG = $clog2(b + 1);
        assign load_data[8*b +: 8] = (head.size >= 2'(LG)) ? shifted[8*b +: 8] : {8{sext}};
        assign data_sram_wdata[8*b +: 8] =
            (in_size == 2'd0) ? in_wdata[7:0] :
            (in_size == 2'd1) ? in_wdata[8*(b%2) +: 8] :
            (in_size == 2'd2) ? in_wdata[8*(b%4) +: 8] :
                                in_wdata[8*(b%8) +: 8];
    end

    assign resp_valid   = !flush && (ale_pend || (head.filled && !head.cancel));
    assign resp_ale     = ale_pend;
    assign resp_is_load = ale_pend ? !ale_wr : !head.wr;
    assign resp_rdata   = (ale_pend || head.wr) ? '0 : load_data;
    assign busy         = (count_q != '0) || ale_pend;

endmodule

// File: tb/tb_mem_access_queue.sv
// Directed self-checking bench for mem_access_queue (DATA_WIDTH 32, DEPTH 4).
module tb_mem_access_queue;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, in_wr, in_signed, flush;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        resp_valid, resp_ready, resp_is_load, resp_ale, busy;
    logic [31:0] resp_rdata;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;
    logic [31:0] hold_data [4] = '{32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};

    mem_access_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_wr             (in_wr),
        .in_size           (in_size),
        .in_signed         (in_signed),
        .in_addr           (in_addr),
        .in_wdata          (in_wdata),
        .flush             (flush),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_is_load      (resp_is_load),
        .resp_rdata        (resp_rdata),
        .resp_ale          (resp_ale),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; in_wr = 1'b0; in_size = 2'd2; in_signed = 1'b0;
        in_addr = 32'h40; in_wdata = '0; flush = 1'b0; data_sram_addr_ok = 1'b1;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; resp_ready = 1'b0;
        tick(); tick();
        check("rst_req", data_sram_req, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_ale", resp_ale, 0);
        check("rst_busy", busy, 0);
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; reset = 1'b0;
        tick();

        // signed byte load from the top lane
        in_valid = 1'b1; in_wr = 1'b0; in_size = 2'd0; in_signed = 1'b1; in_addr = 32'h1003;
        data_sram_addr_ok = 1'b1; #1;
        check("lb_req", data_sram_req, 1);
        check("lb_in_ready", in_ready, 1);
        check("lb_addr", data_sram_addr, 32'h1003);
        check("lb_wr", data_sram_wr, 0);
        check("lb_size", data_sram_size, 0);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF00; #1;
        check("lb_resp_early", resp_valid, 0);
        check("lb_busy", busy, 1);
        tick();
        data_sram_data_ok = 1'b0; #1;
        check("lb_resp_valid", resp_valid, 1);
        check("lb_is_load", resp_is_load, 1);
        check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; #1;
        check("lb_popped", resp_valid, 0);
        check("lb_idle", busy, 0);

        // halfword store in the upper half
        in_valid = 1'b1; in_wr = 1'b1; in_size = 2'd1; in_signed = 1'b0; in_addr = 32'h2002;
        in_wdata = 32'hABCD_1234; data_sram_addr_ok = 1'b1; #1;
        check("sh_wstrb", data_sram_wstrb, 4'b1100);
        check("sh_wdata", data_sram_wdata, 32'h1234_1234);
        check("sh_wr", data_sram_wr, 1);
        check("sh_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        tick();
        data_sram_data_ok = 1'b0; #1;
        check("sh_resp_valid", resp_valid, 1);
        check("sh_is_load", resp_is_load, 0);
        check("sh_rdata", resp_rdata, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // fill all four slots, fifth request must wait for a pop
        in_wr = 1'b0; in_size = 2'd2; in_signed = 1'b0; data_sram_addr_ok = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_addr = 32'h100 + 32'(4 * i); #1;
            check("b2b_in_ready", in_ready, 1);
            tick();
        end
        in_addr = 32'h110; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111; #1;
        check("full_req", data_sram_req, 0);
        check("full_in_ready", in_ready, 0);
        tick();
        data_sram_data_ok = 1'b0; #1;
        check("full_resp_valid", resp_valid, 1);
        check("full_resp_rdata", resp_rdata, 32'h1111_1111);
        check("full_req_still_low", data_sram_req, 0);
        resp_ready = 1'b1; #1;
        check("full_req_during_pop", data_sram_req, 0);
        tick();
        resp_ready = 1'b0; #1;
        check("fifth_req", data_sram_req, 1);
        check("fifth_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0;

        // four responses buffered while the consumer stalls for six cycles
        data_sram_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_sram_rdata = hold_data[i];
            tick();
        end
        data_sram_data_ok = 1'b0;
        tick(); tick(); #1;
        check("hold_valid", resp_valid, 1);
        check("hold_head", resp_rdata, 32'h2222_2222);
        check("hold_busy", busy, 1);
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", resp_valid, 1);
            check("drain_rdata", resp_rdata, hold_data[i]);
            tick();
        end
        resp_ready = 1'b0; #1;
        check("drain_empty", resp_valid, 0);
        check("drain_idle", busy, 0);

        // flush with three loads in flight, then one live load
        in_valid = 1'b1; data_sram_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_addr = 32'h200 + 32'(4 * i); #1;
            check("fl_in_ready", in_ready, 1);
            tick();
        end
        flush = 1'b1; in_addr = 32'h300; #1;
        check("fl_req_blocked", data_sram_req, 0);
        tick();
        flush = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_AAAA; #1;
        check("fl_new_accept", in_ready, 1);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; data_sram_rdata = 32'hBBBB_BBBB; #1;
        check("fl_drop1", resp_valid, 0);
        tick();
        data_sram_rdata = 32'hCCCC_CCCC; #1;
        check("fl_drop2", resp_valid, 0);
        tick();
        data_sram_rdata = 32'h0000_7777; #1;
        check("fl_drop3", resp_valid, 0);
        tick();
        data_sram_data_ok = 1'b0; #1;
        check("fl_live_valid", resp_valid, 1);
        check("fl_live_rdata", resp_rdata, 32'h0000_7777);
        check("fl_live_is_load", resp_is_load, 1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; #1;
        check("fl_idle", busy, 0);

`ifdef MEMQ_ALE_CHECK_EN
        // misaligned word load is answered locally
        in_valid = 1'b1; in_wr = 1'b0; in_size = 2'd2; in_addr = 32'h1002; data_sram_addr_ok = 1'b1; #1;
        check("ale_no_req", data_sram_req, 0);
        check("ale_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; #1;
        check("ale_resp_valid", resp_valid, 1);
        check("ale_flag", resp_ale, 1);
        check("ale_rdata", resp_rdata, 0);
        check("ale_busy", busy, 1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; #1;
        check("ale_cleared", resp_valid, 0);
        check("ale_flag_cleared", resp_ale, 0);
        check("ale_idle", busy, 0);
`else
        // misaligned halfword store goes out with its strobe truncated at the bus edge
        in_valid = 1'b1; in_wr = 1'b1; in_size = 2'd1; in_addr = 32'h1003; in_wdata = 32'h5678;
        data_sram_addr_ok = 1'b1; #1;
        check("mis_req", data_sram_req, 1);
        check("mis_wstrb", data_sram_wstrb, 4'b1000);
        check("mis_ale", resp_ale, 0);
        tick();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0; resp_ready = 1'b1; #1;
        check("mis_resp_valid", resp_valid, 1);
        tick();
        resp_ready = 1'b0; #1;
        check("mis_idle", busy, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_queue.md
# mem_access_queue

Parametrised data-side memory access unit for the MEM stage: it issues load/store requests on the SRAM-like `req`/`addr_ok`/`data_ok` bus and keeps up to DEPTH of them in flight. Responses come back in order, already aligned and sign- or zero-extended. A pipeline flush cancels everything in flight, and late `data_ok` beats for cancelled requests are absorbed. The unit sits between MEM-stage address translation, which supplies physical addresses, and WB, which consumes `resp_*`.

## Interface

Parameters:
- DATA_WIDTH, 32: data bus width. Legal values are 32 and 64. BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32: physical address width.
- DEPTH, 4: outstanding-entry count. Must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid; held stable until accepted
- in_ready  out  1  request accepted this cycle
- in_wr  in  1  1 = store, 0 = load
- in_size  in  2  log2 of bytes; 3 is legal only when DATA_WIDTH = 64
- in_signed  in  1  sign-extend the load result
- in_addr  in  ADDR_WIDTH  physical byte address
- in_wdata  in  DATA_WIDTH  store data, low-aligned
- flush  in  1  cancel all in-flight and buffered requests
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  bus write
- data_sram_size  out  2  equals in_size
- data_sram_wstrb  out  BYTES  byte strobes
- data_sram_addr  out  ADDR_WIDTH  bus address
- data_sram_wdata  out  DATA_WIDTH  lane-replicated store data
- data_sram_addr_ok  in  1  address accepted
- data_sram_data_ok  in  1  data beat
- data_sram_rdata  in  DATA_WIDTH  read data
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes the response
- resp_is_load  out  1  response belongs to a load
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
- resp_ale  out  1  misaligned-access response (ecode 6'h09)
- busy  out  1  any entry allocated or an ALE response pending

## Operation

Entry storage:
- Circular queue of DEPTH entries. Each entry holds {wr, size, signed, addr_lo, filled, cancel, rdata}.
- Three pointers: `alloc` (next free entry), `fill` (oldest unfilled entry), `head` (oldest entry).
- `count` = number of allocated entries, range 0..DEPTH.

Issue path (combinational pass-through):
- data_sram_req = in_valid && count < DEPTH && !flush && !ale_req && !reset.
- in_ready = data_sram_req && addr_ok.
- On acceptance, the entry at `alloc` is written and `alloc` advances.

Store strobe and data:
- wstrb = ((1 << 2^size) − 1) << addr_lo.
- wdata = the low 2^size bytes of in_wdata, replicated across the bus.

Fill and response:
- On data_ok, entry `fill` latches rdata, sets filled, and `fill` advances.
- resp_valid = entry at `head` is filled && !cancel. It pops on resp_ready.
- A filled entry with cancel set pops automatically, without resp_valid.
- Load data = rdata >> (8·addr_lo), truncated to 2^size bytes, then sign- or zero-extended.

Flush:
- Every allocated entry gets cancel set, and any buffered filled responses are discarded.
- New requests are accepted from the next cycle; cancelled entries still occupy slots until their data_ok arrives.
- If data_ok and flush occur in the same cycle, that beat's entry is cancelled.

Boundaries:
- `count` = DEPTH: req is held low.
- Accept and pop in the same cycle leave `count` unchanged.
- Pointers wrap modulo DEPTH.
- data_ok is never backpressured; entries guarantee buffer space.

## Timing

- Reset values: all pointers and `count` 0, all filled and cancel bits 0, resp_valid 0, resp_ale 0, data_sram_req 0, busy 0.
- Issue latency is 0 cycles: req follows in_valid in the same cycle.
- Response latency: resp_valid is asserted the cycle after data_ok at the earliest.
- Throughput: one accept per cycle and one response per cycle, concurrently.
- Reset in mid-operation drops all state. Any data_ok for a pre-reset request is the bus owner's responsibility and must not arrive.

## Configuration

- MEMQ_ALE_CHECK_EN defined:
  - A request whose in_addr is not aligned to 2^size is flagged ale_req and never goes to the bus.
  - It is accepted (in_ready = 1) only when count = 0 and no ALE response is pending.
  - It sets a pending register, giving resp_valid = 1 and resp_ale = 1 the next cycle, with resp_rdata = 0.
  - flush clears the pending register.
- MEMQ_ALE_CHECK_EN undefined:
  - ale_req = 0 and resp_ale is tied 0.
  - Misaligned addresses are issued as-is, with strobe bits beyond BYTES truncated.

## Test plan

- Byte load: ld.b at 0x1003, data_ok rdata = 0x80FF_FF00 -> resp_rdata = 0xFFFF_FF80, resp_is_load = 1.
- Half store: st.h at 0x2002, in_wdata = 0x1234 -> wstrb = 4'b1100, wdata = 0x1234_1234, store response with rdata = 0.
- Back-to-back loads: 4 loads with addr_ok = 1 and data_ok withheld -> 5th request sees req = 0; first data_ok -> resp next cycle, and the 5th is accepted after the pop.
- Flush with 3 in flight: flush, then 3 data_ok beats plus a new load -> only the new load's response appears.
- resp_ready low for 6 cycles with DEPTH = 4 -> all 4 responses held and delivered in order.
- With MEMQ_ALE_CHECK_EN: ld.w at 0x1002 -> no bus req, resp_ale = 1 one cycle after acceptance.
